apu_bus_initiator: RTL

Bus initiator that drives the CPU-side register bus into the APU register decode: a[15:0], cpu_wr, cpu_rd, and the data bus. It accepts queued register-access commands for the sound register window FF10–FF3F. Each command runs as one timed bus cycle (address setup, strobe, hold), and a completion response is returned with read data. Bench models and boot/test sequencers use it to program NR10–NR52 and wave RAM.

---
 rtl/apu_bus_pkg.sv | 27 ++
 rtl/apu_cmd_fifo.sv | 61 ++++++
 rtl/apu_bus_initiator.sv | 102 ++++++++++
 3 files changed

// File: rtl/apu_bus_pkg.sv
// Shared types and constants for the APU register-bus initiator.
// Covers the sound register window FF10-FF3F and the queued command format.
package apu_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_REJECT
   } bus_state_t;

   localparam logic [7:0] APU_ADDR_LO = 8'h10;
   localparam logic [7:0] APU_ADDR_HI = 8'h3F;
   localparam logic [7:0] APU_PAGE    = 8'hFF;

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
   } apu_cmd_t;

   function automatic logic apu_addr_ok(input logic [7:0] addr);
      return (addr >= APU_ADDR_LO) && (addr <= APU_ADDR_HI);
   endfunction

endpackage

// File: rtl/apu_cmd_fifo.sv
// Synchronous command queue. Besides the head it exposes the entry behind it,
// so the bus FSM can choose its next state while the head is being popped.
module apu_cmd_fifo
   import apu_bus_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  logic     pop,
   input  apu_cmd_t din,
   output apu_cmd_t head,
   output apu_cmd_t head_next,
   output logic     full,
   output logic     empty,
   output logic     more
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   apu_cmd_t          mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr, rd_nxt;
   logic [AW:0]       count;
   logic              do_push, do_pop;

   // Push is refused while full even if a pop happens in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_nxt  = rd_ptr + PTR_ONE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (do_pop) rd_ptr <= rd_nxt;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign head      = mem[rd_ptr];
   assign head_next = mem[rd_nxt];
   assign full      = (count == CNT_MAX);
   assign empty     = (count == '0);
   assign more      = (count > CNT_ONE);

endmodule

// File: rtl/apu_bus_initiator.sv
// Drives timed register cycles (setup, strobe, hold) on the APU CPU-side bus
// from a command queue and returns one completion pulse per command.
module apu_bus_initiator
   import apu_bus_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [7:0]  cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [7:0]  rsp_rdata,
   output logic [15:0] a,
   output logic [7:0]  d_out,
   output logic        d_oe,
   input  logic [7:0]  d_in,
   output logic        cpu_wr,
   output logic        cpu_rd,
   output logic        busy
);

   localparam int MAXC = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] PH_SETUP  = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] PH_STROBE = CW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] PH_ONE    = CW'(1);

   bus_state_t    state, state_nx;
   logic [CW-1:0] phase, phase_nx;
   logic [7:0]    rdata_q;
   apu_cmd_t      cmd_in, head, head_next;
   logic          full, empty, more, pop, on_bus, last_phase;

   assign cmd_in    = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
   assign cmd_ready = !full;
   assign pop       = (state == ST_HOLD) || (state == ST_REJECT);

   apu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cmd_valid),
      .pop       (pop),
      .din       (cmd_in),
      .head      (head),
      .head_next (head_next),
      .full      (full),
      .empty     (empty),
      .more      (more)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         phase   <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nx;
         phase <= phase_nx;
         if (state == ST_STROBE && last_phase && !head.wr) rdata_q <= d_in;
      end
   end

   assign last_phase = (phase == '0);

   always_comb begin
      state_nx = state;
      phase_nx = last_phase ? phase : phase - PH_ONE;
      case (state)
         ST_IDLE:   if (!empty) state_nx = apu_addr_ok(head.addr) ? ST_SETUP : ST_REJECT;
         ST_SETUP:  if (last_phase) state_nx = ST_STROBE;
         ST_STROBE: if (last_phase) state_nx = ST_HOLD;
         // The head leaves the queue this cycle, so look one entry further.
         ST_HOLD, ST_REJECT: begin
            if (more) state_nx = apu_addr_ok(head_next.addr) ? ST_SETUP : ST_REJECT;
            else      state_nx = ST_IDLE;
         end
         default:   state_nx = ST_IDLE;
      endcase
      if (state_nx == ST_SETUP && state != ST_SETUP)   phase_nx = PH_SETUP;
      if (state_nx == ST_STROBE && state != ST_STROBE) phase_nx = PH_STROBE;
   end

   // Bus pins decode straight from state so a reset drops strobes at once.
   assign on_bus    = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
   assign a         = on_bus ? {APU_PAGE, head.addr} : 16'h0000;
   assign d_oe      = on_bus && head.wr;
   assign d_out     = d_oe ? head.wdata : 8'h00;
   assign cpu_wr    = (state == ST_STROBE) && head.wr;
   assign cpu_rd    = (state == ST_STROBE) && !head.wr;
   assign rsp_valid = pop;
   assign rsp_err   = (state == ST_REJECT);
   assign rsp_rdata = (state == ST_HOLD && !head.wr) ? rdata_q : 8'h00;
   assign busy      = (state != ST_IDLE) || !empty;

endmodule
